// File: rtl/rv_multicycle_core.sv
// rv_multicycle_core: multi-cycle RV32I/RV64I integer-ALU core with a req/valid fetch port,
// sticky illegal-instruction halt, retire pulse and a combinational debug register read port.
module rv_multicycle_core #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic            retire,
  output logic            zero_f,
  output logic            halt
);
  localparam int unsigned SW = $clog2(XLEN);
  localparam int unsigned IW = $clog2(NREGS);
  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result_q;
  logic [2:0]      f3_q;
  logic            alt_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] imm;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];
  assign imm    = {{(XLEN-12){ir[31]}}, ir[31:20]};
  assign imem_addr = pc;

  // Register reads: x0 and indices beyond the implemented file read as zero.
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  always_comb begin
    rs1_val  = '0;
    rs2_val  = '0;
    dbg_data = '0;
    if (rs1 != 5'd0 && 32'(rs1) < NREGS) rs1_val = regs[rs1[IW-1:0]];
    if (rs2 != 5'd0 && 32'(rs2) < NREGS) rs2_val = regs[rs2[IW-1:0]];
    if (dbg_addr != 5'd0 && 32'(dbg_addr) < NREGS) dbg_data = regs[dbg_addr[IW-1:0]];
  end

  // Decode: legality check and the SUB/SRA selector.
  logic shift_hi_zero;
  logic shift_hi_sra;
  logic illegal_c;
  logic alt_c;
  logic is_r;
  always_comb begin
    shift_hi_zero = (XLEN == 64) ? (ir[31:26] == 6'b000000) : (ir[31:25] == 7'b0000000);
    shift_hi_sra  = (XLEN == 64) ? (ir[31:26] == 6'b010000) : (ir[31:25] == 7'b0100000);
    illegal_c = 1'b0;
    alt_c     = 1'b0;
    is_r      = 1'b0;
    case (opcode)
      OPC_R: begin
        is_r  = 1'b1;
        alt_c = (funct7 == 7'b0100000);
        if (!(funct7 == 7'b0000000 || (alt_c && (funct3 == 3'b000 || funct3 == 3'b101))))
          illegal_c = 1'b1;
      end
      OPC_I: begin
        case (funct3)
          3'b001: illegal_c = !shift_hi_zero;
          3'b101: begin
            alt_c     = shift_hi_sra;
            illegal_c = !(shift_hi_zero || shift_hi_sra);
          end
          default: ;
        endcase
      end
      default: illegal_c = 1'b1;
    endcase
    if (NREGS < 32 && (rd[4] || rs1[4] || (is_r && rs2[4]))) illegal_c = 1'b1;
  end

  // ALU on the operands latched in DECODE.
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_c;
  always_comb begin
    shamt = op_b[SW-1:0];
    case (f3_q)
      3'b000:  alu_c = alt_q ? (op_a - op_b) : (op_a + op_b);
      3'b001:  alu_c = op_a << shamt;
      3'b010:  alu_c = XLEN'($signed(op_a) < $signed(op_b));
      3'b011:  alu_c = XLEN'(op_a < op_b);
      3'b100:  alu_c = op_a ^ op_b;
      3'b101:  alu_c = alt_q ? XLEN'($signed(op_a) >>> shamt) : (op_a >> shamt);
      3'b110:  alu_c = op_a | op_b;
      default: alu_c = op_a & op_b;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      pc       <= PC_RESET;
      ir       <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
      f3_q     <= '0;
      alt_q    <= 1'b0;
      rd_q     <= '0;
      imem_req <= 1'b0;
      retire   <= 1'b0;
      zero_f   <= 1'b0;
      halt     <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) regs[IW'(i)] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          // The request is raised one cycle before a fetch can complete.
          if (imem_req && imem_rvalid) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          if (illegal_c) begin
            halt  <= 1'b1;
            state <= S_HALT;
          end else begin
            op_a  <= rs1_val;
            op_b  <= is_r ? rs2_val : imm;
            f3_q  <= funct3;
            alt_q <= alt_c;
            rd_q  <= rd;
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          result_q <= alu_c;
          zero_f   <= (alu_c == '0);
          retire   <= 1'b1;
          state    <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (rd_q != 5'd0) regs[rd_q[IW-1:0]] <= result_q;
          pc       <= pc + XLEN'(4);
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: begin
          imem_req <= 1'b0;
          halt     <= 1'b1;
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Bench for rv_multicycle_core: random RV32I ALU programs scored against a mnemonic-level model,
// plus a 64-bit / 16-register instance running a short fixed program.
module tb_rv_multicycle_core;
  localparam int OP_ADD = 0,  OP_SUB = 1,  OP_SLL = 2,  OP_SLT = 3,  OP_SLTU = 4;
  localparam int OP_XOR = 5,  OP_SRL = 6,  OP_SRA = 7,  OP_OR = 8,   OP_AND = 9;
  localparam int OP_ADDI = 10, OP_SLTI = 11, OP_SLTIU = 12, OP_XORI = 13, OP_ORI = 14;
  localparam int OP_ANDI = 15, OP_SLLI = 16, OP_SRLI = 17, OP_SRAI = 18, OP_BAD = -1;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        retire;
  logic        zero_f;
  logic        halt;

  logic        reset2;
  logic        req2;
  logic [63:0] addr2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic [4:0]  dbg_addr2;
  logic [63:0] dbg_data2;
  logic        retire2;
  logic        zero2;
  logic        halt2;
  logic [31:0] prog2 [8];

  always #5 clk = ~clk;

  rv_multicycle_core #(.XLEN(32), .NREGS(32), .PC_RESET(32'd0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .retire(retire), .zero_f(zero_f), .halt(halt));

  rv_multicycle_core #(.XLEN(64), .NREGS(16), .PC_RESET(64'd0)) dut64 (
    .clk(clk), .reset(reset2), .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2), .dbg_addr(dbg_addr2),
    .dbg_data(dbg_data2), .retire(retire2), .zero_f(zero2), .halt(halt2));

  // Zero-wait memory for the 64-bit instance.
  assign rvalid2 = req2;
  assign rdata2  = prog2[addr2[4:2]];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1, logic [2:0] f3, int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] i12, int rs1, logic [2:0] f3, int rd);
    return {i12, 5'(rs1), f3, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc(int op, int rd, int rs1, int rs2, int imm);
    logic [11:0] i12;
    i12 = 12'(imm);
    case (op)
      OP_ADD:   return enc_r(7'h00, rs2, rs1, 3'd0, rd);
      OP_SUB:   return enc_r(7'h20, rs2, rs1, 3'd0, rd);
      OP_SLL:   return enc_r(7'h00, rs2, rs1, 3'd1, rd);
      OP_SLT:   return enc_r(7'h00, rs2, rs1, 3'd2, rd);
      OP_SLTU:  return enc_r(7'h00, rs2, rs1, 3'd3, rd);
      OP_XOR:   return enc_r(7'h00, rs2, rs1, 3'd4, rd);
      OP_SRL:   return enc_r(7'h00, rs2, rs1, 3'd5, rd);
      OP_SRA:   return enc_r(7'h20, rs2, rs1, 3'd5, rd);
      OP_OR:    return enc_r(7'h00, rs2, rs1, 3'd6, rd);
      OP_AND:   return enc_r(7'h00, rs2, rs1, 3'd7, rd);
      OP_ADDI:  return enc_i(i12, rs1, 3'd0, rd);
      OP_SLTI:  return enc_i(i12, rs1, 3'd2, rd);
      OP_SLTIU: return enc_i(i12, rs1, 3'd3, rd);
      OP_XORI:  return enc_i(i12, rs1, 3'd4, rd);
      OP_ORI:   return enc_i(i12, rs1, 3'd6, rd);
      OP_ANDI:  return enc_i(i12, rs1, 3'd7, rd);
      OP_SLLI:  return enc_i({7'h00, 5'(imm)}, rs1, 3'd1, rd);
      OP_SRLI:  return enc_i({7'h00, 5'(imm)}, rs1, 3'd5, rd);
      OP_SRAI:  return enc_i({7'h20, 5'(imm)}, rs1, 3'd5, rd);
      default:  return 32'h0000007F;
    endcase
  endfunction

  // Architectural meaning of each mnemonic on 32-bit values.
  function automatic logic [31:0] ref_result(int op, logic [31:0] a, logic [31:0] r2, int imm);
    logic [11:0] i12;
    logic [31:0] b;
    int sh;
    i12 = 12'(imm);
    b  = (op >= OP_ADDI) ? {{20{i12[11]}}, i12} : r2;
    sh = (op >= OP_ADDI) ? (imm & 31) : int'(r2[4:0]);
    case (op)
      OP_ADD, OP_ADDI:   return a + b;
      OP_SUB:            return a - b;
      OP_SLL, OP_SLLI:   return a << sh;
      OP_SLT, OP_SLTI:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU, OP_SLTIU: return (a < b) ? 32'd1 : 32'd0;
      OP_XOR, OP_XORI:   return a ^ b;
      OP_SRL, OP_SRLI:   return a >> sh;
      OP_SRA, OP_SRAI:   return 32'($signed(a) >>> sh);
      OP_OR, OP_ORI:     return a | b;
      default:           return a & b;
    endcase
  endfunction

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic        zf;
    int          gap;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  bit          m_first;
  bit          r2done = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc    = '0;
    m_first = 1'b1;
  endtask

  // Serve one fetch: random rvalid noise until the request, then 'waits' idle cycles, then data.
  task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int imm,
                       input int waits, input bit commit);
    int guard;
    logic [31:0] res;
    exp_t e;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 100) begin
      imem_rvalid = 1'($urandom_range(0, 1));
      imem_rdata  = $urandom;
      @(negedge clk);
      guard++;
    end
    if (imem_req !== 1'b1) begin
      check("fetch_req", 64'(imem_req), 64'd1);
      return;
    end
    check("fetch_addr", 64'(imem_addr), 64'(m_pc));
    for (int w = 0; w < waits; w++) begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      @(negedge clk);
      check("wait_req", 64'(imem_req), 64'd1);
      check("wait_addr", 64'(imem_addr), 64'(m_pc));
    end
    imem_rvalid = 1'b1;
    imem_rdata  = enc(op, rd, rs1, rs2, imm);
    if (commit) begin
      res   = ref_result(op, m_regs[rs1], m_regs[rs2], imm);
      e.rd  = 5'(rd);
      e.val = (rd == 0) ? 32'd0 : res;
      e.zf  = (res == 32'd0);
      e.gap = m_first ? -1 : 4 + waits;
      sb.push_back(e);
      if (rd != 0) m_regs[rd] = res;
      m_pc    = m_pc + 32'd4;
      m_first = 1'b0;
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
  endtask

  // Monitor: every retire pops an expectation; the written register is read back a cycle later.
  int          cyc = 0;
  int          last_ret = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_val;
  exp_t        mon_e;
  always @(negedge clk) begin
    cyc++;
    if (pend) begin
      check("dbg_reg", 64'(dbg_data), 64'(pend_val));
      pend = 1'b0;
    end
    if (retire === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_retire", 64'(retire), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("zero_f", 64'(zero_f), 64'(mon_e.zf));
        if (mon_e.gap > 0) check("retire_gap", 64'(cyc - last_ret), 64'(mon_e.gap));
        dbg_addr = mon_e.rd;
        pend_val = mon_e.val;
        pend     = 1'b1;
      end
      last_ret = cyc;
    end
  end

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || pend) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int op, rd, rs1, rs2, imm, waits;
    reset       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    dbg_addr    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_retire", 64'(retire), 64'd0);
    check("rst_zero_f", 64'(zero_f), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("first_req", 64'(imem_req), 64'd1);
    check("first_addr", 64'(imem_addr), 64'd0);

    issue(OP_ADDI, 1, 0, 0, 5, 0, 1);
    issue(OP_ADDI, 2, 0, 0, -3, 0, 1);
    issue(OP_ADD, 3, 1, 2, 0, 0, 1);
    issue(OP_SUB, 4, 1, 1, 0, 0, 1);
    issue(OP_ADDI, 0, 0, 0, 7, 0, 1);
    issue(OP_SLTI, 5, 2, 0, 0, 0, 1);
    issue(OP_SLTIU, 6, 2, 0, 0, 0, 1);
    issue(OP_SRAI, 7, 2, 0, 1, 0, 1);
    issue(OP_ADD, 8, 3, 3, 0, 3, 1);

    for (int n = 0; n < 80; n++) begin
      op    = $urandom_range(0, 18);
      rd    = $urandom_range(0, 31);
      rs1   = $urandom_range(0, 31);
      rs2   = $urandom_range(0, 31);
      imm   = (op >= OP_SLLI) ? $urandom_range(0, 31) : $urandom_range(0, 4095);
      waits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      issue(op, rd, rs1, rs2, imm, waits, 1);
    end
    drain();

    // Illegal opcode at PC 8 halts with the PC frozen.
    pulse_reset();
    issue(OP_ADDI, 1, 0, 0, 9, 0, 1);
    issue(OP_ADD, 2, 1, 1, 0, 1, 1);
    issue(OP_BAD, 0, 0, 0, 0, 0, 0);
    drain();
    repeat (4) @(negedge clk);
    check("halt_set", 64'(halt), 64'd1);
    check("halt_req", 64'(imem_req), 64'd0);
    check("halt_pc", 64'(imem_addr), 64'd8);
    repeat (6) @(negedge clk);
    check("halt_sticky", 64'(halt), 64'd1);

    // Reset during EXECUTE of ADDI x9,x0,1 aborts it; x9 is then read through x10.
    pulse_reset();
    issue(OP_ADDI, 9, 0, 0, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_req", 64'(imem_req), 64'd0);
    check("abort_retire", 64'(retire), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    issue(OP_ADD, 10, 9, 0, 0, 0, 1);
    issue(OP_ADDI, 11, 9, 0, 1, 0, 1);
    drain();

    for (int i = 0; i < 500 && !r2done; i++) @(negedge clk);
    check("x64_done", 64'(r2done), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // 64-bit, 16-register instance: shifts use six-bit shamt, x17 is illegal.
  int retires2 = 0;
  always @(negedge clk) if (retire2 === 1'b1) retires2++;

  initial begin
    logic [4:0]  idx [6];
    logic [63:0] expv [6];
    reset2    = 1'b0;
    dbg_addr2 = '0;
    prog2[0] = enc_i(12'hFFF, 0, 3'd0, 1);
    prog2[1] = enc_i(12'd60, 1, 3'd5, 1);
    prog2[2] = enc_r(7'h00, 1, 1, 3'd0, 3);
    prog2[3] = enc_i(12'hFF8, 0, 3'd0, 2);
    prog2[4] = enc_i(12'h401, 2, 3'd5, 2);
    prog2[5] = enc_i(12'd40, 1, 3'd1, 4);
    prog2[6] = enc_r(7'h00, 2, 1, 3'd0, 17);
    prog2[7] = 32'h0000007F;
    idx[0] = 5'd1;  expv[0] = 64'h0000_0000_0000_000F;
    idx[1] = 5'd2;  expv[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    idx[2] = 5'd3;  expv[2] = 64'h0000_0000_0000_001E;
    idx[3] = 5'd4;  expv[3] = 64'h0000_0F00_0000_0000;
    idx[4] = 5'd17; expv[4] = 64'd0;
    idx[5] = 5'd0;  expv[5] = 64'd0;
    repeat (2) @(negedge clk);
    reset2 = 1'b1;
    for (int i = 0; i < 200 && halt2 !== 1'b1; i++) @(negedge clk);
    check("x64_halt", 64'(halt2), 64'd1);
    repeat (2) @(negedge clk);
    check("x64_req", 64'(req2), 64'd0);
    check("x64_pc", addr2, 64'd24);
    check("x64_retires", 64'(retires2), 64'd6);
    check("x64_zero_f", 64'(zero2), 64'd0);
    for (int i = 0; i < 6; i++) begin
      dbg_addr2 = idx[i];
      #1;
      check("x64_dbg", dbg_data2, expv[i]);
    end
    r2done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
